// File: rtl/data_mem_ctrl.sv
// Data-memory controller: byte-enabled stores and full-word loads on an internal
// word array, with a configurable number of wait states ahead of each access.
module data_mem_ctrl #(
    parameter int DataWidth  = 32,
    parameter int Depth      = 1024,
    parameter int WaitStates = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 request,
    input  logic                 we_re,
    input  logic [3:0]           mask,
    input  logic [DataWidth-1:0] addr,
    input  logic [DataWidth-1:0] store_data,
    output logic                 data_valid,
    output logic [DataWidth-1:0] load_data,
    output logic                 stall,
    output logic                 addr_err
);

    localparam int AW = $clog2(Depth);
    localparam logic [3:0] WS = WaitStates[3:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [3:0]             wait_cnt_r;
    logic [DataWidth-1:0]   addr_r;
    logic                   we_r;
    logic [3:0]             mask_r;
    logic [DataWidth-1:0]   data_r;
    logic [AW-1:0]          word_idx_s;
    logic                   out_of_range_s;
    logic                   addr_lsb_unused_s;
    logic [DataWidth-1:0]   mem_r [Depth];

    assign word_idx_s        = addr_r[AW+1:2];
    assign out_of_range_s    = |addr_r[DataWidth-1:AW+2];
    // Byte offset is not used: accesses are word-wide and lanes come pre-aligned.
    assign addr_lsb_unused_s = ^addr_r[1:0];

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (request) begin
                    next_state_s = (WS != 4'd0) ? WAIT : ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt_r <= 4'd1) begin
                    next_state_s = ACCESS;
                end else begin
                    next_state_s = WAIT;
                end
            end
            ACCESS:  next_state_s = RESP;
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Stall output: combinational so the pipeline freezes in the request cycle itself.
    always_comb begin
        stall = 1'b0;
        case (state_r)
            IDLE:    stall = request;
            WAIT:    stall = 1'b1;
            ACCESS:  stall = 1'b1;
            RESP:    stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    // Request capture, wait counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 4'd0;
            addr_r     <= '0;
            we_r       <= 1'b0;
            mask_r     <= 4'd0;
            data_r     <= '0;
            data_valid <= 1'b0;
            load_data  <= '0;
            addr_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    data_valid <= 1'b0;
                    load_data  <= '0;
                    addr_err   <= 1'b0;
                    if (request) begin
                        addr_r     <= addr;
                        we_r       <= we_re;
                        mask_r     <= mask;
                        data_r     <= store_data;
                        wait_cnt_r <= WS;
                    end
                end
                WAIT: begin
                    wait_cnt_r <= wait_cnt_r - 4'd1;
                end
                ACCESS: begin
                    data_valid <= 1'b1;
                    addr_err   <= out_of_range_s;
                    if (!we_r && !out_of_range_s) begin
                        load_data <= mem_r[word_idx_s];
                    end else begin
                        load_data <= '0;
                    end
                end
                RESP: begin
                    data_valid <= 1'b0;
                    load_data  <= '0;
                    addr_err   <= 1'b0;
                end
                default: begin
                    data_valid <= 1'b0;
                    load_data  <= '0;
                    addr_err   <= 1'b0;
                end
            endcase
        end
    end

    // Array write; reset suppresses a store landing in the same cycle. Contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && state_r == ACCESS && we_r && !out_of_range_s) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_r[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= data_r[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory controller that sits directly downstream of the memory stage. It accepts the stage's `request`, `we_re`, `mask`, aligned store data and byte address, and performs a byte-enabled write or a full-word read on an internal word array. Its `data_valid` and `load_data` outputs feed back into the memory stage's load-wrapper inputs, and `stall` freezes the pipeline while an access is in flight. Access latency is set by a configurable number of wait states.

## Interface
- `DataWidth`, 32, data and address width; fixed at 32.
- `Depth`, 1024, number of 32-bit words in the array; must be a power of 2. `AW = $clog2(Depth)`.
- `WaitStates`, 1, extra cycles inserted before each access; legal range 0..15.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `request`  in  1  access request, level-sensitive.
- `we_re`  in  1  1 = store, 0 = load.
- `mask`  in  4  byte enables for stores; bit i enables byte lane i. Ignored for loads.
- `addr`  in  32  byte address (the ALU result).
- `store_data`  in  32  store data, already lane-aligned.
- `data_valid`  out  1  one-cycle completion pulse for both loads and stores.
- `load_data`  out  32  read word; valid while `data_valid` = 1.
- `stall`  out  1  holds the pipeline while an access is pending.
- `addr_err`  out  1  out-of-range flag; pulses together with `data_valid`.

## Operation
- The FSM has four states: IDLE, WAIT, ACCESS and RESP.
- **IDLE**
  - When `request` = 1: latch `addr`, `we_re`, `mask` and `store_data`, and load the wait counter with `WaitStates`.
  - Next state is WAIT if `WaitStates` > 0, otherwise ACCESS.
- **WAIT**
  - Decrement the counter each cycle.
  - Go to ACCESS in the cycle the counter reaches 1, so WAIT lasts exactly `WaitStates` cycles.
- **ACCESS**
  - Word index is `addr_q[AW+1:2]`.
  - The address is out of range when `addr_q[31:AW+2]` != 0.
  - Store in range: write byte i of the word when `mask_q[i]` = 1. A mask of 0000 writes nothing.
  - Load in range: register the full word into `load_data`.
  - Out of range: no write, `load_data` is set to 0, and the `addr_err` register is set.
  - Store (any range): `load_data` is set to 0.
  - Next state is RESP.
- **RESP**
  - `data_valid` = 1 for this single cycle.
  - `addr_err` stays 1 if it was set in ACCESS.
  - `request` is ignored in this cycle.
  - Next state is IDLE.
- `stall` is combinational: `(IDLE & request) | WAIT | ACCESS`. It is 0 in RESP, so the pipeline advances in the same cycle that the response is presented.
- Changes on `request` or any other input after capture are ignored until the FSM returns to IDLE.
- Array contents are not cleared by reset.
- Latched inputs are not checked for misalignment; the upstream stage is responsible for the mask and lane alignment.

## Timing
- Reset values: state = IDLE, `data_valid` = 0, `load_data` = 0, `addr_err` = 0, wait counter = 0.
  - `stall` = `request` while in IDLE after reset.
- Reset has priority over every transition.
  - If `rst` is sampled high in the ACCESS cycle, no array write occurs.
  - If `rst` is sampled high in any state, the next state is IDLE.
- Latency: with the request sampled in IDLE at cycle T:
  - ACCESS occurs at T+W+1 and `data_valid` = 1 at T+W+2.
  - `stall` = 1 for cycles T..T+W+1 (W+2 cycles).
- Back-to-back requests: the earliest next acceptance is at cycle T+W+3, so throughput is one access per W+3 cycles.
- `data_valid` and `addr_err` are registered and are never high outside RESP.
- `load_data` returns to 0 in the cycle after RESP.

## Test plan
- Full-word store then load, W=0:
  - Store 0xDEADBEEF, mask 1111, `addr` 0x10 at T → `data_valid` at T+2, stall=1 for T..T+1.
  - Load 0x10 at T+3 → `load_data` = 0xDEADBEEF at T+5.
- Byte store: after the previous test, store 0x00AB0000 with mask 0100 to 0x10 → a subsequent load returns 0xDEABBEEF.
- W=3: request at T → stall=1 for T..T+4, `data_valid` at T+5 only, and the request is held low afterwards.
- Out of range, Depth=1024:
  - Store to 0x1000 → `addr_err` = 1 with `data_valid`, and the word at 0x0 is unchanged.
  - Load from 0x1000 → `load_data` = 0, `addr_err` = 1.
- Reset mid-access: store 0x12345678 to 0x20 (old value 0xCAFEF00D) with `rst` = 1 in the ACCESS cycle → all outputs 0, state IDLE, and a later load returns 0xCAFEF00D.
- Held `request` = 1 across the RESP cycle, W=0 → exactly one access completes per 3-cycle interval, with no double capture in RESP.
